hswish_out_collector: RTL and testbench

HSWISH_OUT_COLLECTOR -- requirements
Module: hswish_out_collector

---
 rtl/hswish_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 92 +++++++++
 rtl/hswish_out_collector.sv | 133 +++++++++++++
 tb/tb_hswish_out_collector.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hswish_pkg.sv
// ---------------------------------------------------------------------------
// hswish_pkg
// Shared definitions for the h-swish activation output path.
//   dataWidth / fracWidth : Q8.8 activation sample format
//   packed_word_t         : two samples packed into one transfer word
//   fifo_entry_t          : packed word plus its end-of-frame marker
// ---------------------------------------------------------------------------
package hswish_pkg;

    localparam int dataWidth = 16;
    localparam int fracWidth = 8;

    typedef logic [2*dataWidth-1:0] packed_word_t;

    typedef struct packed {
        logic         last;
        packed_word_t data;
    } fifo_entry_t;

    // Pack an (odd, even) sample pair; the even sample occupies the low half.
    function automatic packed_word_t pack_pair(input logic [dataWidth-1:0] odd_smp,
                                               input logic [dataWidth-1:0] even_smp);
        return {odd_smp, even_smp};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : write request (accepted when not full, or when a pop
//                happens in the same cycle)
//   wdata_i    : write data
//   pop_i      : read request (ignored while empty)
//   rdata_o    : head entry, valid whenever empty_o is low
//   count_o    : occupancy 0..DEPTH
//   full_o     : occupancy == DEPTH
//   empty_o    : occupancy == 0
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_en_s;
    logic             rd_en_s;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A pop frees the slot a simultaneous push needs, so full does not block it.
    assign rd_en_s = pop_i && !empty_o;
    assign wr_en_s = push_i && (!full_o || rd_en_s);

    // Next-state pointers and occupancy.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en_s) begin
            wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_en_s) begin
            rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are only observed through count-qualified reads.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/hswish_out_collector.sv
// ---------------------------------------------------------------------------
// hswish_out_collector
// Packs pairs of h-swish output samples into 2*dataWidth words, tags the
// final word of each frame and buffers words in a FWFT FIFO.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : sample strobe (no backpressure)
//   in_data     : signed activation sample
//   out_valid   : head word available
//   out_ready   : downstream accepts head word
//   out_data    : packed word, first sample in the low half
//   out_last    : head word closes a frame
//   almost_full : occupancy >= DEPTH-AF_MARGIN, upstream must stop
//   overflow    : sticky, a completed word was dropped on a full FIFO
//   frame_done  : one-cycle pulse after the last word of a frame is popped
// ---------------------------------------------------------------------------
module hswish_out_collector
    import hswish_pkg::*;
#(
    parameter int dataWidth = hswish_pkg::dataWidth,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 64,
    parameter int AF_MARGIN = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [dataWidth-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*dataWidth-1:0] out_data,
    output logic                   out_last,
    output logic                   almost_full,
    output logic                   overflow,
    output logic                   frame_done
);

    localparam int WORD_W  = 2*dataWidth;
    localparam int ENTRY_W = WORD_W + 1;
    localparam int SCNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int CNT_W   = $clog2(DEPTH+1);
    localparam logic [SCNT_W-1:0] LAST_IDX = SCNT_W'(FRAME_LEN-1);
    localparam logic [CNT_W-1:0]  AF_LEVEL = CNT_W'(DEPTH-AF_MARGIN);

    logic [SCNT_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [dataWidth-1:0] half_q, half_d;
    logic                 overflow_q, overflow_d;
    logic                 frame_done_q, frame_done_d;

    logic                 last_sample_s;
    logic                 push_s;
    logic [ENTRY_W-1:0]   push_entry_s;
    logic                 pop_s;
    logic                 drop_s;
    logic [ENTRY_W-1:0]   head_s;
    logic [CNT_W-1:0]     fifo_count_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;

    // Sample packing and frame position tracking.
    always_comb begin
        sample_cnt_d  = sample_cnt_q;
        half_d        = half_q;
        push_s        = 1'b0;
        push_entry_s  = '0;
        last_sample_s = (sample_cnt_q == LAST_IDX);
        if (in_valid) begin
            // Frame position parity decides even/odd; frames restart at 0,
            // so an odd-length frame ends on an even position.
            if (sample_cnt_q[0] == 1'b0) begin
                if (last_sample_s) begin
                    push_s       = 1'b1;
                    push_entry_s = {1'b1, {dataWidth{1'b0}}, in_data};
                end else begin
                    half_d = in_data;
                end
            end else begin
                push_s       = 1'b1;
                push_entry_s = {last_sample_s, pack_pair(in_data, half_q)};
            end
            sample_cnt_d = last_sample_s ? '0 : sample_cnt_q + SCNT_W'(1);
        end else begin
            sample_cnt_d = sample_cnt_q;
        end
    end

    assign pop_s  = out_ready && !fifo_empty_s;
    assign drop_s = push_s && fifo_full_s && !pop_s;

    // Sticky drop flag and end-of-frame pulse.
    always_comb begin
        overflow_d   = overflow_q | drop_s;
        frame_done_d = pop_s & head_s[WORD_W];
    end

    // Packing, flag and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_q <= '0;
            half_q       <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            half_q       <= half_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (push_entry_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Head entry is masked while empty so unwritten storage never leaks out.
    assign out_valid   = !fifo_empty_s;
    assign out_data    = fifo_empty_s ? '0 : head_s[WORD_W-1:0];
    assign out_last    = !fifo_empty_s && head_s[WORD_W];
    assign almost_full = (fifo_count_s >= AF_LEVEL);
    assign overflow    = overflow_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hswish_out_collector.sv
// Bench for hswish_out_collector: a default instance (FRAME_LEN=64) and a
// FRAME_LEN=3 instance share one clock; 'sel' picks which one is driven.
module tb_hswish_out_collector;
    import hswish_pkg::*;

    logic clk;
    logic rst_n;

    logic        iv0, or0, ov0, ol0, af0, of0, fd0;
    logic [15:0] id0;
    logic [31:0] od0;
    logic        iv3, or3, ov3, ol3, af3, of3, fd3;
    logic [15:0] id3;
    logic [31:0] od3;

    int sel;

    logic        o_valid, o_last, o_af, o_ovf, o_fd;
    logic [31:0] o_data;
    assign o_valid = (sel != 0) ? ov3 : ov0;
    assign o_last  = (sel != 0) ? ol3 : ol0;
    assign o_af    = (sel != 0) ? af3 : af0;
    assign o_ovf   = (sel != 0) ? of3 : of0;
    assign o_fd    = (sel != 0) ? fd3 : fd0;
    assign o_data  = (sel != 0) ? od3 : od0;

    hswish_out_collector dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_last(ol0),
        .almost_full(af0), .overflow(of0), .frame_done(fd0)
    );

    hswish_out_collector #(.FRAME_LEN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_data(id3),
        .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_last(ol3),
        .almost_full(af3), .overflow(of3), .frame_done(fd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int          frame_len;
    int          m_cnt;
    int          m_count;
    logic [15:0] m_half;
    logic        m_ovf;
    logic        m_fd;
    logic [32:0] exp_q[$];

    task automatic model_reset();
        m_cnt   = 0;
        m_count = 0;
        m_half  = 16'h0000;
        m_ovf   = 1'b0;
        m_fd    = 1'b0;
        exp_q.delete();
        frame_len = (sel != 0) ? 3 : 64;
    endtask

    // Drive one clock of stimulus on the selected DUT and advance the model.
    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input logic v, input logic [15:0] d, input logic r);
        logic        pop;
        logic        push;
        logic        full_b;
        logic        last;
        logic [32:0] w;
        if (sel != 0) begin iv3 = v; id3 = d; or3 = r; end
        else          begin iv0 = v; id0 = d; or0 = r; end
        @(posedge clk);
        pop    = r && (m_count != 0);
        full_b = (m_count == 16);
        push   = 1'b0;
        w      = '0;
        m_fd   = 1'b0;
        if (v) begin
            last = (m_cnt == frame_len - 1);
            if ((m_cnt % 2) == 0) begin
                if (last) begin push = 1'b1; w = {1'b1, 16'h0000, d}; end
                else m_half = d;
            end else begin
                push = 1'b1;
                w    = {last, d, m_half};
            end
            m_cnt = last ? 0 : m_cnt + 1;
        end
        if (pop) begin
            m_fd = exp_q[0][32];
            void'(exp_q.pop_front());
            m_count--;
        end
        if (push) begin
            if (full_b && !pop) m_ovf = 1'b1;
            else begin exp_q.push_back(w); m_count++; end
        end
        @(negedge clk);
        iv0 = 1'b0; or0 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        iv0 = 1'b1; id0 = 16'hFFFF; or0 = 1'b1;
        iv3 = 1'b1; id3 = 16'hFFFF; or3 = 1'b1;
        repeat (2) @(negedge clk);
        iv0 = 1'b0; or0 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        sel = 0;
        @(negedge clk);
        rst_n = 1'b0;
        iv0 = 1'b1; id0 = 16'h1111; or0 = 1'b1;
        iv3 = 1'b1; id3 = 16'h2222; or3 = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({ov0, ol0, af0, of0, fd0} !== 5'b0) begin n_fail++;
            $display("FAIL reset_flags0 got %b want 00000", {ov0, ol0, af0, of0, fd0}); end
        n_checks++; if (od0 !== 32'h0) begin n_fail++;
            $display("FAIL reset_data0 got %h want 00000000", od0); end
        n_checks++; if ({ov3, ol3, af3, of3, fd3} !== 5'b0) begin n_fail++;
            $display("FAIL reset_flags3 got %b want 00000", {ov3, ol3, af3, of3, fd3}); end
        iv0 = 1'b0; or0 = 1'b0; iv3 = 1'b0; or3 = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_pair();
        sel = 0;
        do_reset();
        cycle(1'b1, 16'h0100, 1'b1);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++;
            $display("FAIL pair_half_valid got %b want 0", o_valid); end
        cycle(1'b1, 16'h0200, 1'b1);
        n_checks++; if (o_valid !== 1'b1) begin n_fail++;
            $display("FAIL pair_valid got %b want 1", o_valid); end
        n_checks++; if (o_data !== 32'h02000100) begin n_fail++;
            $display("FAIL pair_data got %h want 02000100", o_data); end
        n_checks++; if ({o_last, o_data} !== exp_q[0]) begin n_fail++;
            $display("FAIL pair_sb got %h want %h", {o_last, o_data}, exp_q[0]); end
        cycle(1'b0, 16'h0000, 1'b1);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++;
            $display("FAIL pair_drained got %b want 0", o_valid); end
    endtask

    task automatic test_frame3();
        sel = 1;
        do_reset();
        cycle(1'b1, 16'h0001, 1'b0);
        cycle(1'b1, 16'h0002, 1'b0);
        cycle(1'b1, 16'h0003, 1'b0);
        n_checks++; if ({o_last, o_data} !== 33'h0_00020001) begin n_fail++;
            $display("FAIL f3_word0 got %h want 000020001", {o_last, o_data}); end
        n_checks++; if ({o_last, o_data} !== exp_q[0]) begin n_fail++;
            $display("FAIL f3_sb0 got %h want %h", {o_last, o_data}, exp_q[0]); end
        cycle(1'b0, 16'h0000, 1'b1);
        n_checks++; if (o_fd !== 1'b0) begin n_fail++;
            $display("FAIL f3_fd_early got %b want 0", o_fd); end
        n_checks++; if ({o_last, o_data} !== 33'h1_00000003) begin n_fail++;
            $display("FAIL f3_word1 got %h want 100000003", {o_last, o_data}); end
        cycle(1'b0, 16'h0000, 1'b1);
        n_checks++; if (o_fd !== 1'b1 || o_fd !== m_fd) begin n_fail++;
            $display("FAIL f3_fd_pulse got %b want 1", o_fd); end
        cycle(1'b0, 16'h0000, 1'b0);
        n_checks++; if (o_fd !== 1'b0) begin n_fail++;
            $display("FAIL f3_fd_clear got %b want 0", o_fd); end
    endtask

    task automatic test_stream();
        sel = 0;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            if (m_count != 0) begin
                n_checks++; if ({o_last, o_data} !== exp_q[0]) begin n_fail++;
                    $display("FAIL stream_word[%0d] got %h want %h", i, {o_last, o_data}, exp_q[0]); end
            end
            cycle(1'b1, 16'($urandom_range(0, 65535)), 1'b1);
            n_checks++; if (o_fd !== m_fd) begin n_fail++;
                $display("FAIL stream_fd[%0d] got %b want %b", i, o_fd, m_fd); end
        end
        n_checks++; if ({o_last, o_data} !== exp_q[0] || o_last !== 1'b1) begin n_fail++;
            $display("FAIL stream_last got %h want %h", {o_last, o_data}, exp_q[0]); end
        cycle(1'b0, 16'h0000, 1'b1);
        n_checks++; if (o_fd !== 1'b1) begin n_fail++;
            $display("FAIL stream_fd_end got %b want 1", o_fd); end
    endtask

    task automatic test_fill();
        sel = 0;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            cycle(1'b1, 16'(i*3 + 1), 1'b0);
            n_checks++; if (o_af !== (m_count >= 13)) begin n_fail++;
                $display("FAIL fill_af[%0d] got %b want %b", i, o_af, (m_count >= 13)); end
            n_checks++; if (o_valid !== (m_count != 0) || o_ovf !== 1'b0) begin n_fail++;
                $display("FAIL fill_flags[%0d] got v=%b o=%b want v=%b o=0", i, o_valid, o_ovf, (m_count != 0)); end
        end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 16'hDEAD, 1'b0);
        cycle(1'b1, 16'hBEEF, 1'b0);
        n_checks++; if (o_ovf !== 1'b1 || o_ovf !== m_ovf) begin n_fail++;
            $display("FAIL ovf_set got %b want 1", o_ovf); end
        cycle(1'b0, 16'h0000, 1'b0);
        n_checks++; if (o_ovf !== 1'b1) begin n_fail++;
            $display("FAIL ovf_sticky got %b want 1", o_ovf); end
        for (int k = 0; k < 16; k++) begin
            n_checks++; if ({o_last, o_data} !== exp_q[0] || o_valid !== 1'b1) begin n_fail++;
                $display("FAIL ovf_drain[%0d] got v=%b %h want %h", k, o_valid, {o_last, o_data}, exp_q[0]); end
            cycle(1'b0, 16'h0000, 1'b1);
        end
        n_checks++; if (o_valid !== 1'b0 || o_ovf !== 1'b1) begin n_fail++;
            $display("FAIL ovf_empty got v=%b o=%b want v=0 o=1", o_valid, o_ovf); end
    endtask

    task automatic test_full_pushpop();
        sel = 0;
        do_reset();
        n_checks++; if (o_ovf !== 1'b0) begin n_fail++;
            $display("FAIL fpp_ovf_cleared got %b want 0", o_ovf); end
        for (int i = 0; i < 32; i++) cycle(1'b1, 16'(16'h4000 + i), 1'b0);
        cycle(1'b1, 16'hA5A5, 1'b0);
        n_checks++; if ({o_last, o_data} !== exp_q[0]) begin n_fail++;
            $display("FAIL fpp_head got %h want %h", {o_last, o_data}, exp_q[0]); end
        cycle(1'b1, 16'h5A5A, 1'b1);
        n_checks++; if (o_ovf !== 1'b0 || o_af !== 1'b1 || o_valid !== 1'b1) begin n_fail++;
            $display("FAIL fpp_flags got o=%b af=%b v=%b want o=0 af=1 v=1", o_ovf, o_af, o_valid); end
        for (int k = 0; k < 16; k++) begin
            n_checks++; if ({o_last, o_data} !== exp_q[0] || o_valid !== 1'b1) begin n_fail++;
                $display("FAIL fpp_drain[%0d] got v=%b %h want %h", k, o_valid, {o_last, o_data}, exp_q[0]); end
            if (k == 15) begin
                n_checks++; if (o_data !== 32'h5A5AA5A5) begin n_fail++;
                    $display("FAIL fpp_tail got %h want 5a5aa5a5", o_data); end
            end
            cycle(1'b0, 16'h0000, 1'b1);
        end
        n_checks++; if (o_valid !== 1'b0) begin n_fail++;
            $display("FAIL fpp_count got v=%b want 0 after 16 pops", o_valid); end
    endtask

    task automatic test_reset_mid();
        sel = 0;
        do_reset();
        cycle(1'b1, 16'h1111, 1'b0);
        cycle(1'b1, 16'h2222, 1'b0);
        cycle(1'b1, 16'h3333, 1'b0);
        n_checks++; if (o_valid !== 1'b1) begin n_fail++;
            $display("FAIL rmid_pre got %b want 1", o_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({o_valid, o_last, o_af, o_ovf, o_fd} !== 5'b0 || o_data !== 32'h0) begin n_fail++;
            $display("FAIL rmid_async got %b %h want 00000 00000000", {o_valid, o_last, o_af, o_ovf, o_fd}, o_data); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 16'hAAAA, 1'b0);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++;
            $display("FAIL rmid_fresh_half got %b want 0", o_valid); end
        cycle(1'b1, 16'h5555, 1'b0);
        n_checks++; if (o_data !== 32'h5555AAAA || o_last !== 1'b0 || o_valid !== 1'b1) begin n_fail++;
            $display("FAIL rmid_word got v=%b %h want 1 5555aaaa", o_valid, o_data); end
    endtask

    initial begin
        rst_n = 1'b1;
        sel = 0;
        iv0 = 1'b0; id0 = 16'h0; or0 = 1'b0;
        iv3 = 1'b0; id3 = 16'h0; or3 = 1'b0;
        model_reset();
        test_reset();
        test_pair();
        test_frame3();
        test_stream();
        test_fill();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
